// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and defaults for the bit-serial adder sequencer.
package serial_add_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADD  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// Single-bit full-adder cell, reused every cycle by the serial adder.
module serial_add_ctrl_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell stepped over WIDTH bits, LSB first.
// Optional signed-overflow output o_Ovf is enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    input  logic             i_Cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_Sum,
`ifdef SERIAL_ADD_OVF_EN
    output logic             o_Ovf,
`endif
    output logic             o_Cout
);

    localparam int            CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] res_r;
    logic [WIDTH-1:0] res_nxt_s;
    logic [CW-1:0]    cnt_r;
    logic             carry_r;
    logic             sum_bit_s;
    logic             cout_s;
    logic             last_s;

    serial_add_ctrl_fa u_fa (
        .a    (a_sh_r[0]),
        .b    (b_sh_r[0]),
        .cin  (carry_r),
        .sum  (sum_bit_s),
        .cout (cout_s)
    );

    assign last_s    = (state_r == ADD) && (cnt_r == LAST_BIT);
    assign res_nxt_s = {sum_bit_s, res_r[WIDTH-1:1]};

    // State register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_start) begin
                    state_nxt_s = ADD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ADD: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = ADD;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Operand shifters, carry flop, bit counter and registered results.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            a_sh_r  <= {WIDTH{1'b0}};
            b_sh_r  <= {WIDTH{1'b0}};
            res_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            carry_r <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_Sum   <= {WIDTH{1'b0}};
            o_Cout  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        a_sh_r  <= i_A;
                        b_sh_r  <= i_B;
                        res_r   <= {WIDTH{1'b0}};
                        carry_r <= i_Cin;
                        cnt_r   <= {CW{1'b0}};
                        o_busy  <= 1'b1;
                    end else begin
                        o_busy  <= 1'b0;
                    end
                end
                ADD: begin
                    a_sh_r  <= a_sh_r >> 1;
                    b_sh_r  <= b_sh_r >> 1;
                    res_r   <= res_nxt_s;
                    carry_r <= cout_s;
                    if (last_s) begin
                        // Counter parks at WIDTH-1; it is reloaded on the next accept.
                        o_Sum  <= res_nxt_s;
                        o_Cout <= cout_s;
                        o_done <= 1'b1;
                    end else begin
                        cnt_r  <= cnt_r + CW'(1'b1);
                    end
                end
                DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                end
                default: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    // Signed overflow: carry into the MSB (carry_r on the last bit) vs carry out.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_Ovf <= 1'b0;
        end else if (last_s) begin
            o_Ovf <= carry_r ^ cout_s;
        end else begin
            o_Ovf <= o_Ovf;
        end
    end
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed, table-driven bench for serial_add_ctrl (WIDTH=4), with
// hand sequences for ignored starts, mid-operation reset and back-to-back adds.
module tb_serial_add_ctrl;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int total;
    int bad;

    logic [W-1:0] prev_sum;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[9];

    serial_add_ctrl #(.WIDTH(W)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_start   (start),
        .i_A       (a_in),
        .i_B       (b_in),
        .i_Cin     (cin),
        .o_busy    (busy),
        .o_done    (done),
        .o_Sum     (sum),
`ifdef SERIAL_ADD_OVF_EN
        .o_Ovf     (ovf),
`endif
        .o_Cout    (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One start pulse, then check done timing, held result and final values.
    task automatic run_add(input vec_t v, input string nm);
        @(negedge clk);
        a_in = v.a; b_in = v.b; cin = v.c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a_in = ~v.a; b_in = ~v.b; cin = ~v.c;
        chk({nm, ".busy0"}, 32'(busy), 32'd1);
        for (int k = 1; k < W; k++) begin
            @(negedge clk);
            chk({nm, ".done_early"}, 32'(done), 32'd0);
            chk({nm, ".held"}, 32'(sum), 32'(prev_sum));
        end
        @(negedge clk);
        chk({nm, ".done"}, 32'(done), 32'd1);
        chk({nm, ".busy"}, 32'(busy), 32'd1);
        chk({nm, ".sum"}, 32'(sum), 32'(v.exp_sum));
        chk({nm, ".cout"}, 32'(cout), 32'(v.exp_cout));
`ifdef SERIAL_ADD_OVF_EN
        chk({nm, ".ovf"}, 32'(ovf), 32'(v.exp_ovf));
`endif
        @(negedge clk);
        chk({nm, ".done_fall"}, 32'(done), 32'd0);
        chk({nm, ".busy_fall"}, 32'(busy), 32'd0);
        prev_sum = v.exp_sum;
    endtask

    initial begin
        int ndone;
        int first_k;
        int last_k;
        logic [W-1:0] got_sum;
        logic got_cout;

        total = 0; bad = 0; prev_sum = '0;
        rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;

        vecs[0] = '{4'h7, 4'h9, 1'b0, 4'h0, 1'b1, 1'b0};
        vecs[1] = '{4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0};
        vecs[2] = '{4'h3, 4'h4, 1'b0, 4'h7, 1'b0, 1'b0};
        vecs[3] = '{4'h5, 4'h6, 1'b0, 4'hB, 1'b0, 1'b1};
        vecs[4] = '{4'hA, 4'h5, 1'b1, 4'h0, 1'b1, 1'b0};
        vecs[5] = '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1};
        vecs[6] = '{4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1};
        vecs[7] = '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0};
        vecs[8] = '{4'hC, 4'hC, 1'b0, 4'h8, 1'b1, 1'b0};

        #12;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.sum", 32'(sum), 32'd0);
        chk("rst.cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        chk("rst.ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_add(vecs[i], $sformatf("vec%0d", i));
        end

        // Start while busy is ignored; operands changed after accept have no effect.
        @(negedge clk);
        a_in = 4'h5; b_in = 4'h6; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a_in = 4'hF; b_in = 4'hF; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; got_sum = '0; got_cout = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                got_sum = sum;
                got_cout = cout;
            end
        end
        chk("ign.ndone", 32'(ndone), 32'd1);
        chk("ign.sum", 32'(got_sum), 32'hB);
        chk("ign.cout", 32'(got_cout), 32'd0);
        prev_sum = 4'hB;

        // Asynchronous reset mid-ADD.
        @(negedge clk);
        a_in = 4'h7; b_in = 4'h9; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.busy", 32'(busy), 32'd0);
        chk("arst.done", 32'(done), 32'd0);
        chk("arst.sum", 32'(sum), 32'd0);
        chk("arst.cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("arst.nodone", 32'(ndone), 32'd0);
        prev_sum = '0;
        run_add(vecs[2], "post_rst");

        // Start held high: back-to-back adds every W+2 cycles.
        @(negedge clk);
        a_in = 4'h1; b_in = 4'h1; cin = 1'b0; start = 1'b1;
        ndone = 0; first_k = -1; last_k = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                chk("b2b.sum", 32'(sum), 32'd2);
                if (first_k < 0) first_k = k;
                else chk("b2b.period", 32'(k - last_k), 32'(W + 2));
                last_k = k;
            end
        end
        start = 1'b0;
        chk("b2b.first", 32'(first_k), 32'(W));
        chk("b2b.ndone", 32'(ndone), 32'd3);
        for (int k = 0; k < 8; k++) @(negedge clk);
        chk("b2b.idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder sequencer. Time-multiplexes a single full-adder cell across WIDTH bit positions: one bit per clock, LSB first.
- Latches the operands on a start request, steps a bit counter and a carry register, and assembles the sum.
- Reports completion with a one-cycle done pulse. Results feed the FND display path in place of a ripple adder.

Parameters:
- WIDTH, 4, operand/sum width in bits; legal range 2..16.

Ports:
- i_clk  input  1  system clock, rising edge
- i_reset_n  input  1  asynchronous active-low reset
- i_start  input  1  start request; sampled only in IDLE
- i_A  input  WIDTH  operand A; latched on accepted start
- i_B  input  WIDTH  operand B; latched on accepted start
- i_Cin  input  1  carry-in; latched on accepted start
- o_busy  output  1  high in ADD and DONE states
- o_done  output  1  one-cycle completion pulse
- o_Sum  output  WIDTH  registered sum; holds until next completion
- o_Cout  output  1  registered carry-out; holds until next completion

Behaviour:
- Clock and reset: one clock, i_clk. i_reset_n is asynchronous, active-low; deassertion is synchronised externally.
- Reset values: state=IDLE, o_busy=0, o_done=0, o_Sum=0, o_Cout=0, bit counter=0, carry reg=0, operand regs=0.
- States:
  - IDLE: on an edge with i_start=1, latch i_A, i_B into shift regs, carry reg<=i_Cin, counter<=0, go to ADD. With i_start=0, stay in IDLE.
  - ADD: each edge, the full-adder cell takes (A_sh[0], B_sh[0], carry reg). Its sum bit shifts into the result reg at the MSB end (right shift). Carry reg<=cell carry-out. A_sh and B_sh shift right. Counter increments.
  - ADD exit: when counter==WIDTH-1 at the edge, the final bit is processed, o_Sum<=completed result, o_Cout<=cell carry-out, and the state goes to DONE.
  - DONE: o_done=1 for exactly this one cycle; next edge goes to IDLE.
- Latency: start accepted at edge 0; o_Sum/o_Cout update and o_done rises at edge WIDTH; o_done falls at edge WIDTH+1. Throughput is one add per WIDTH+2 cycles.
- i_start while o_busy=1 (ADD or DONE) is ignored; no queueing. i_start held high continuously gives back-to-back adds with one IDLE cycle between them.
- Operand changes after acceptance have no effect.
- o_Sum/o_Cout change only at the completion edge, never mid-operation.
- Arithmetic: o_Sum = (A+B+Cin) mod 2^WIDTH; o_Cout = bit WIDTH of the full sum.
- Reset asserted mid-operation aborts immediately to reset values; no done pulse is generated.
- Counter width is $clog2(WIDTH); no wrap beyond WIDTH-1.

Optional Feature:
- Macro SERIAL_ADD_OVF_EN.
- Defined:
  - Adds output o_Ovf (1 bit, reset 0) = signed overflow = (carry into MSB) XOR (carry out of MSB).
  - Carry into MSB is the carry reg value at the final ADD edge.
  - o_Ovf updates with o_Sum and holds until the next completion.
- Undefined: the port and its logic are absent; no other behaviour changes.

Decomposition:
- Package serial_add_pkg holds:
  - the state typedef (IDLE, ADD, DONE; 2-bit encoding);
  - the default WIDTH constant.
- Sub-module: one instance of the team's existing full-adder cell as the bit datapath. Controller FSM, counter, shift regs and carry flop live in serial_add_ctrl.

Test Plan:
- WIDTH=4: A=7, B=9, Cin=0, start pulse -> o_done high exactly at edge 4, o_Sum=0, o_Cout=1, o_busy high for edges 1..5.
- A=0xF, B=0x0, Cin=1 -> o_Sum=0x0, o_Cout=1. Then A=3, B=4, Cin=0 -> o_Sum=7, o_Cout=0, with the previous result held until the new done.
- Start accepted with A=5, B=6; change operands and pulse i_start at edge 2 -> start ignored, o_Sum=0xB, o_Cout=0, single done pulse.
- Drop i_reset_n asynchronously mid-ADD at edge 2 -> outputs and state go to reset immediately; no o_done. New start after release gives correct results.
- i_start held high for 20 cycles with A=1, B=1 -> done pulses every 6 cycles, o_Sum=2 each time.
- With SERIAL_ADD_OVF_EN: A=7, B=1, Cin=0 -> o_Sum=8, o_Cout=0, o_Ovf=1. A=0xF, B=0x1 -> o_Ovf=0, o_Cout=1.
